// File: rtl/lsu_bus_bridge_pkg.sv
// Shared encodings for the load/store-to-bus bridge: FSM states, store size codes,
// full byte-enable constant and the misaligned-store predicate.
package lsu_bus_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [1:0] SZ_B    = 2'b00;
    localparam logic [1:0] SZ_H    = 2'b01;
    localparam logic [1:0] SZ_W    = 2'b10;
    localparam logic [3:0] BE_FULL = 4'hF;

    // Halfwords need bit 0 clear, words need both low bits clear; bytes never fault.
    function automatic logic misaligned(input logic [1:0] wsize, input logic [1:0] addr_lo);
        logic res;
        res = 1'b0;
        case (wsize)
            SZ_B:    res = 1'b0;
            SZ_H:    res = addr_lo[0];
            SZ_W:    res = (addr_lo != 2'b00);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsu_watchdog.sv
// Cycle counter for an outstanding bus access; tc_c marks the cycle in which the
// TIMEOUT-th enabled cycle completes. TIMEOUT = 0 removes the counter entirely.
module lsu_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tc_c
);

    if (TIMEOUT == 0) begin : g_off
        logic unused_wd;
        assign unused_wd = clk ^ rst_n ^ en ^ clr;
        assign tc_c      = 1'b0;
    end else begin : g_on
        localparam int unsigned CW = $clog2(TIMEOUT + 1);

        logic [CW-1:0] cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
            end else if (clr) begin
                cnt <= '0;
            end else if (en) begin
                cnt <= cnt + CW'(1);
            end
        end

        assign tc_c = en && (cnt == CW'(TIMEOUT - 1));
    end

endmodule

// File: rtl/lsu_bus_bridge.sv
// Latches one core load/store at a time, runs it on the req/gnt + rvalid data bus and
// returns a single-cycle ack, with error reporting for misaligned stores, bus errors and timeouts.
module lsu_bus_bridge
    import lsu_bus_bridge_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          core_sel_i,
    input  logic          core_wen_i,
    input  logic [AW-1:0] core_addr_i,
    input  logic [DW-1:0] core_wdata_i,
    input  logic [3:0]    core_wmask_i,
    input  logic [1:0]    core_wsize_i,
    output logic [DW-1:0] core_rdata_o,
    output logic          core_ack_o,
    output logic          core_err_o,
    output logic          bus_req_o,
    output logic          bus_we_o,
    output logic [AW-1:0] bus_addr_o,
    output logic [DW-1:0] bus_wdata_o,
    output logic [3:0]    bus_be_o,
    input  logic          bus_gnt_i,
    input  logic          bus_rvalid_i,
    input  logic [DW-1:0] bus_rdata_i,
    input  logic          bus_err_i
);

    state_e state;
    logic   wd_en_c;
    logic   wd_clr_c;
    logic   wd_tc_c;
    logic   rsp_fire_c;

    assign wd_en_c  = (state == ST_REQ) || (state == ST_RSP);
    assign wd_clr_c = (state == ST_IDLE);

    // A response counts in RSP, or in REQ only together with its grant.
    assign rsp_fire_c = bus_rvalid_i && (((state == ST_REQ) && bus_gnt_i) || (state == ST_RSP));

    lsu_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (wd_en_c),
        .clr   (wd_clr_c),
        .tc_c  (wd_tc_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            core_rdata_o <= '0;
            core_ack_o   <= 1'b0;
            core_err_o   <= 1'b0;
            bus_req_o    <= 1'b0;
            bus_we_o     <= 1'b0;
            bus_addr_o   <= '0;
            bus_wdata_o  <= '0;
            bus_be_o     <= '0;
        end else begin
            core_ack_o <= 1'b0;
            core_err_o <= 1'b0;

            if (rsp_fire_c) begin
                core_ack_o   <= 1'b1;
                core_err_o   <= bus_err_i;
                core_rdata_o <= bus_we_o ? '0 : bus_rdata_i;
                bus_req_o    <= 1'b0;
                state        <= ST_DONE;
            end else if (wd_tc_c) begin
                core_ack_o   <= 1'b1;
                core_err_o   <= 1'b1;
                core_rdata_o <= '0;
                bus_req_o    <= 1'b0;
                state        <= ST_DONE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (core_sel_i) begin
                            if (core_wen_i && misaligned(core_wsize_i, core_addr_i[1:0])) begin
                                core_ack_o   <= 1'b1;
                                core_err_o   <= 1'b1;
                                core_rdata_o <= '0;
                                state        <= ST_DONE;
                            end else begin
                                bus_req_o   <= 1'b1;
                                bus_we_o    <= core_wen_i;
                                bus_addr_o  <= {core_addr_i[AW-1:2], 2'b00};
                                bus_wdata_o <= core_wdata_i;
                                bus_be_o    <= core_wen_i ? core_wmask_i : BE_FULL;
                                state       <= ST_REQ;
                            end
                        end
                    end
                    ST_REQ: begin
                        if (bus_gnt_i) begin
                            bus_req_o <= 1'b0;
                            state     <= ST_RSP;
                        end
                    end
                    ST_RSP: begin
                        state <= ST_RSP;
                    end
                    // The acked request may still be on the core port here, so it is ignored.
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Directed bench for lsu_bus_bridge: scoreboard queues hold expected bus transactions and
// core acks, drained by negedge monitors; exact-cycle checks are made inline.
module tb_lsu_bus_bridge;

    localparam int unsigned AW      = 32;
    localparam int unsigned DW      = 32;
    localparam int unsigned TIMEOUT = 8;

    logic          clk;
    logic          rst_n;
    logic          core_sel_i;
    logic          core_wen_i;
    logic [AW-1:0] core_addr_i;
    logic [DW-1:0] core_wdata_i;
    logic [3:0]    core_wmask_i;
    logic [1:0]    core_wsize_i;
    logic [DW-1:0] core_rdata_o;
    logic          core_ack_o;
    logic          core_err_o;
    logic          bus_req_o;
    logic          bus_we_o;
    logic [AW-1:0] bus_addr_o;
    logic [DW-1:0] bus_wdata_o;
    logic [3:0]    bus_be_o;
    logic          bus_gnt_i;
    logic          bus_rvalid_i;
    logic [DW-1:0] bus_rdata_i;
    logic          bus_err_i;

    lsu_bus_bridge #(
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .core_sel_i   (core_sel_i),
        .core_wen_i   (core_wen_i),
        .core_addr_i  (core_addr_i),
        .core_wdata_i (core_wdata_i),
        .core_wmask_i (core_wmask_i),
        .core_wsize_i (core_wsize_i),
        .core_rdata_o (core_rdata_o),
        .core_ack_o   (core_ack_o),
        .core_err_o   (core_err_o),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_be_o     (bus_be_o),
        .bus_gnt_i    (bus_gnt_i),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i),
        .bus_err_i    (bus_err_i)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } ack_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } txn_t;

    ack_t exp_ack[$];
    txn_t exp_txn[$];
    ack_t mon_ack;
    txn_t mon_txn;
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wmask, input logic [1:0] wsize);
        core_sel_i   = 1'b1;
        core_wen_i   = wen;
        core_addr_i  = addr;
        core_wdata_i = wdata;
        core_wmask_i = wmask;
        core_wsize_i = wsize;
    endtask

    task automatic set_bus(input logic gnt, input logic rvalid, input logic [31:0] rdata, input logic err);
        bus_gnt_i    = gnt;
        bus_rvalid_i = rvalid;
        bus_rdata_i  = rdata;
        bus_err_i    = err;
    endtask

    task automatic wait_ack(input int max_cycles);
        for (int i = 0; i < max_cycles && !core_ack_o; i++) tick();
        chk("ack_seen", 32'(core_ack_o), 32'd1);
    endtask

    // Ack scoreboard.
    always @(negedge clk) begin
        if (rst_n && core_ack_o) begin
            if (exp_ack.size() == 0) begin
                chk("ack_unexpected_qsize", 32'(exp_ack.size()), 32'd1);
            end else begin
                mon_ack = exp_ack.pop_front();
                chk("sb_ack_rdata", core_rdata_o, mon_ack.rdata);
                chk("sb_ack_err", 32'(core_err_o), 32'(mon_ack.err));
            end
        end
    end

    // Bus transaction scoreboard: one entry per granted request.
    always @(negedge clk) begin
        if (rst_n && bus_req_o && bus_gnt_i) begin
            if (exp_txn.size() == 0) begin
                chk("txn_unexpected_qsize", 32'(exp_txn.size()), 32'd1);
            end else begin
                mon_txn = exp_txn.pop_front();
                chk("sb_txn_addr", bus_addr_o, mon_txn.addr);
                chk("sb_txn_we", 32'(bus_we_o), 32'(mon_txn.we));
                chk("sb_txn_be", 32'(bus_be_o), 32'(mon_txn.be));
                if (mon_txn.we) chk("sb_txn_wdata", bus_wdata_o, mon_txn.wdata);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        core_sel_i = 1'b0;
        drive_req(1'b0, 32'h0, 32'h0, 4'h0, 2'b00);
        core_sel_i = 1'b0;
        set_bus(1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        chk("rst_ack", 32'(core_ack_o), 32'd0);
        chk("rst_err", 32'(core_err_o), 32'd0);
        chk("rst_req", 32'(bus_req_o), 32'd0);
        chk("rst_rdata", core_rdata_o, 32'd0);
        chk("rst_be", 32'(bus_be_o), 32'd0);
        chk("rst_addr", bus_addr_o, 32'd0);
        rst_n = 1'b1;
        tick();

        // Load, gnt+rvalid with req: ack two cycles after sel is seen.
        exp_txn.push_back(txn_t'{32'h100, 1'b0, 4'hF, 32'h0});
        exp_ack.push_back(ack_t'{32'hDEADBEEF, 1'b0});
        drive_req(1'b0, 32'h100, 32'h0, 4'h0, 2'b10);
        tick();
        chk("t1_req", 32'(bus_req_o), 32'd1);
        chk("t1_be", 32'(bus_be_o), 32'hF);
        chk("t1_we", 32'(bus_we_o), 32'd0);
        chk("t1_addr", bus_addr_o, 32'h100);
        chk("t1_no_early_ack", 32'(core_ack_o), 32'd0);
        set_bus(1'b1, 1'b1, 32'hDEADBEEF, 1'b0);
        tick();
        chk("t1_ack", 32'(core_ack_o), 32'd1);
        chk("t1_rdata", core_rdata_o, 32'hDEADBEEF);
        chk("t1_err", 32'(core_err_o), 32'd0);
        set_bus(1'b0, 1'b0, 32'h0, 1'b0);
        core_sel_i = 1'b0;
        tick();
        chk("t1_ack_pulse", 32'(core_ack_o), 32'd0);
        chk("t1_rdata_hold", core_rdata_o, 32'hDEADBEEF);
        tick();

        // Misaligned half store: immediate error ack, no bus request.
        exp_ack.push_back(ack_t'{32'h0, 1'b1});
        drive_req(1'b1, 32'h103, 32'hBEEF0000, 4'b1000, 2'b01);
        tick();
        chk("t3_ack", 32'(core_ack_o), 32'd1);
        chk("t3_err", 32'(core_err_o), 32'd1);
        chk("t3_rdata", core_rdata_o, 32'h0);
        chk("t3_req", 32'(bus_req_o), 32'd0);
        core_sel_i = 1'b0;
        tick();
        chk("t3_req_after", 32'(bus_req_o), 32'd0);
        chk("t3_ack_pulse", 32'(core_ack_o), 32'd0);
        tick();

        // Store word with delayed grant and response; sel held through the ack cycle.
        exp_txn.push_back(txn_t'{32'h204, 1'b1, 4'hF, 32'h12345678});
        exp_ack.push_back(ack_t'{32'h0, 1'b0});
        drive_req(1'b1, 32'h204, 32'h12345678, 4'hF, 2'b10);
        tick();
        for (int c = 1; c < 4; c++) begin
            chk("t2_req_held", 32'(bus_req_o), 32'd1);
            chk("t2_addr_held", bus_addr_o, 32'h204);
            tick();
        end
        chk("t2_req_c4", 32'(bus_req_o), 32'd1);
        chk("t2_be", 32'(bus_be_o), 32'hF);
        chk("t2_we", 32'(bus_we_o), 32'd1);
        chk("t2_wdata", bus_wdata_o, 32'h12345678);
        set_bus(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        set_bus(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t2_req_drop", 32'(bus_req_o), 32'd0);
        tick();
        set_bus(1'b0, 1'b1, 32'hFFFFFFFF, 1'b0);
        tick();
        set_bus(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t2_ack", 32'(core_ack_o), 32'd1);
        chk("t2_rdata_store", core_rdata_o, 32'h0);
        chk("t2_err", 32'(core_err_o), 32'd0);
        tick();
        core_sel_i = 1'b0;
        chk("t2_ack_pulse", 32'(core_ack_o), 32'd0);
        chk("t2_no_reissue", 32'(bus_req_o), 32'd0);
        tick();
        chk("t2_no_reissue2", 32'(bus_req_o), 32'd0);
        tick();

        // Load answered with a bus error.
        exp_txn.push_back(txn_t'{32'h500, 1'b0, 4'hF, 32'h0});
        exp_ack.push_back(ack_t'{32'hA5A5A5A5, 1'b1});
        drive_req(1'b0, 32'h500, 32'h0, 4'h0, 2'b10);
        tick();
        set_bus(1'b1, 1'b1, 32'hA5A5A5A5, 1'b1);
        tick();
        chk("t5_ack", 32'(core_ack_o), 32'd1);
        chk("t5_err", 32'(core_err_o), 32'd1);
        set_bus(1'b0, 1'b0, 32'h0, 1'b0);
        core_sel_i = 1'b0;
        tick();
        tick();

        // Grant never arrives: watchdog error-ack after TIMEOUT cycles in REQ.
        exp_ack.push_back(ack_t'{32'h0, 1'b1});
        drive_req(1'b0, 32'h400, 32'h0, 4'h0, 2'b10);
        tick();
        for (int c = 1; c < int'(TIMEOUT); c++) begin
            chk("t4_req_held", 32'(bus_req_o), 32'd1);
            tick();
        end
        chk("t4_req_last", 32'(bus_req_o), 32'd1);
        chk("t4_no_early_ack", 32'(core_ack_o), 32'd0);
        tick();
        chk("t4_ack", 32'(core_ack_o), 32'd1);
        chk("t4_err", 32'(core_err_o), 32'd1);
        chk("t4_rdata", core_rdata_o, 32'h0);
        chk("t4_req_drop", 32'(bus_req_o), 32'd0);
        core_sel_i = 1'b0;
        set_bus(1'b0, 1'b1, 32'hBAD0BAD0, 1'b0);
        tick();
        chk("t4_late_ack", 32'(core_ack_o), 32'd0);
        tick();
        set_bus(1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        chk("t4_late_rdata", core_rdata_o, 32'h0);
        chk("t4_late_ack2", 32'(core_ack_o), 32'd0);

        // Asynchronous reset while waiting in RSP, then a normal load.
        exp_txn.push_back(txn_t'{32'h600, 1'b0, 4'hF, 32'h0});
        drive_req(1'b0, 32'h600, 32'h0, 4'h0, 2'b10);
        tick();
        set_bus(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        set_bus(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t5r_in_rsp_req", 32'(bus_req_o), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5r_addr", bus_addr_o, 32'h0);
        chk("t5r_be", 32'(bus_be_o), 32'h0);
        chk("t5r_ack", 32'(core_ack_o), 32'd0);
        chk("t5r_req", 32'(bus_req_o), 32'd0);
        core_sel_i = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        exp_txn.push_back(txn_t'{32'h604, 1'b0, 4'hF, 32'h0});
        exp_ack.push_back(ack_t'{32'h11223344, 1'b0});
        drive_req(1'b0, 32'h604, 32'h0, 4'h0, 2'b10);
        tick();
        chk("t5r_post_req", 32'(bus_req_o), 32'd1);
        set_bus(1'b1, 1'b1, 32'h11223344, 1'b0);
        tick();
        chk("t5r_post_ack", 32'(core_ack_o), 32'd1);
        chk("t5r_post_rdata", core_rdata_o, 32'h11223344);
        set_bus(1'b0, 1'b0, 32'h0, 1'b0);
        core_sel_i = 1'b0;
        tick();
        tick();

        // Back-to-back SB then LW with sel held high throughout.
        exp_txn.push_back(txn_t'{32'h300, 1'b1, 4'b0010, 32'h0000AB00});
        exp_txn.push_back(txn_t'{32'h300, 1'b0, 4'hF, 32'h0});
        exp_ack.push_back(ack_t'{32'h0, 1'b0});
        exp_ack.push_back(ack_t'{32'hCAFEF00D, 1'b0});
        set_bus(1'b1, 1'b1, 32'hCAFEF00D, 1'b0);
        drive_req(1'b1, 32'h301, 32'h0000AB00, 4'b0010, 2'b00);
        wait_ack(20);
        tick();
        drive_req(1'b0, 32'h300, 32'h0, 4'h0, 2'b10);
        tick();
        wait_ack(20);
        chk("t6_lw_rdata", core_rdata_o, 32'hCAFEF00D);
        core_sel_i = 1'b0;
        set_bus(1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        tick();

        chk("txn_queue_drained", 32'(exp_txn.size()), 32'd0);
        chk("ack_queue_drained", 32'(exp_ack.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
